// File: rtl/invsqrt_out_buffer.sv
// invsqrt_out_buffer: first-word-fall-through output FIFO for the inverse
// square root pipeline. Results enter on DataValid, leave on a ready/valid
// handshake, and ce_out throttles the upstream pipeline once free space
// drops to AF_THRESH entries or fewer. A result that arrives while the FIFO
// is full and not being read is dropped and raises the sticky overflow flag.
// Optional: define INVSQRT_OBUF_STATS_EN to add a saturating 16-bit
// drop_cnt output counting dropped results.
module invsqrt_out_buffer #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              DataIn,
  input  logic                     DataValid,
  output logic                     ce_out,
  output logic [31:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef INVSQRT_OBUF_STATS_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Elaboration guard: pointer wrap relies on DEPTH being a power of two.
  generate
    if ((DEPTH < 4) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("invsqrt_out_buffer: DEPTH must be a power of two in 4..64");
    end
  endgenerate

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] free_cnt;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;

  // Handshake decode. A read in the same cycle frees the slot a full FIFO
  // needs, so a simultaneous read and write is always accepted.
  always_comb begin
    full     = (level == LW'(DEPTH));
    m_valid  = (level != '0);
    rd_en    = m_valid & m_ready;
    wr_en    = DataValid & (~full | rd_en);
    drop     = DataValid & full & ~rd_en;
    free_cnt = LW'(DEPTH) - level;
    ce_out   = (int'(free_cnt) > AF_THRESH);
    m_data   = mem[rd_ptr];
  end

  // Storage array; contents need no reset since m_valid masks stale words.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= DataIn;
  end

  // Pointers, occupancy and sticky overflow. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef INVSQRT_OBUF_STATS_EN
  // Dropped-result counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          drop_cnt <= '0;
    else if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_invsqrt_out_buffer.sv
// Directed bench for invsqrt_out_buffer (DEPTH=8, AF_THRESH=3).
module tb_invsqrt_out_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DataIn;
  logic        DataValid;
  logic        ce_out;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  level;
  logic        overflow;
`ifdef INVSQRT_OBUF_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int vectors = 0;
  int fails   = 0;

  invsqrt_out_buffer #(.DEPTH(8), .AF_THRESH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .DataIn    (DataIn),
    .DataValid (DataValid),
    .ce_out    (ce_out),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .level     (level),
    .overflow  (overflow)
`ifdef INVSQRT_OBUF_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_out;
    int next_in;
    logic tog;

    rst = 1'b0; DataIn = '0; DataValid = 1'b0; m_ready = 1'b0;
    #2;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ce", ce_out, 1);
    step();
    rst = 1'b1;

    // Two writes with consumer stalled; first edge after release is live.
    DataIn = 32'h3F800000; DataValid = 1'b1;
    step();
    chk("lat1_level", level, 1);
    chk("lat1_mvalid", m_valid, 1);
    chk("lat1_data", m_data, 32'h3F800000);
    DataIn = 32'h3F000000;
    step();
    DataValid = 1'b0;
    chk("w2_level", level, 2);
    chk("w2_mvalid", m_valid, 1);
    chk("w2_data", m_data, 32'h3F800000);

    // Fill to level 5: free space 3 stalls upstream.
    DataValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      DataIn = 32'h40000000 + i;
      if (i == 2) chk("ce_lvl4", ce_out, 1);
      step();
    end
    DataValid = 1'b0;
    chk("af_level", level, 5);
    chk("af_ce", ce_out, 0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pop_level", level, 4);
    chk("pop_ce", ce_out, 1);
    chk("pop_data", m_data, 32'h3F000000);

    // Asynchronous reset at level 4, mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mvalid", m_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_ce", ce_out, 1);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_mvalid", m_valid, 0);

    // Fill to full, then simultaneous read+write while full.
    DataValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      DataIn = 32'h100 + i;
      step();
    end
    chk("full_level", level, 8);
    chk("full_ce", ce_out, 0);
    chk("full_head", m_data, 32'h100);
    DataIn = 32'h55; m_ready = 1'b1;
    step();
    DataValid = 1'b0;
    chk("rw_full_level", level, 8);
    chk("rw_full_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      chk("rw_drain", m_data, 32'h100 + i);
      step();
    end
    chk("rw_new_last", m_data, 32'h55);
    chk("rw_lvl1", level, 1);
    // Simultaneous read+write at level 1.
    DataValid = 1'b1; DataIn = 32'h66;
    step();
    DataValid = 1'b0;
    chk("rw1_level", level, 1);
    chk("rw1_data", m_data, 32'h66);
    step();
    chk("empty_level", level, 0);
    chk("empty_mvalid", m_valid, 0);
    // m_ready while empty has no effect.
    step();
    chk("ready_empty_level", level, 0);
    m_ready = 1'b0;

    // Overflow: 8 words then 0xDEADBEEF while full.
    DataValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      DataIn = 32'h200 + i;
      step();
    end
    DataIn = 32'hDEADBEEF;
    step();
    DataValid = 1'b0;
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
`ifdef INVSQRT_OBUF_STATS_EN
    chk("ovf_dropcnt", drop_cnt, 1);
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", m_data, 32'h200 + i);
      step();
    end
    m_ready = 1'b0;
    chk("ovf_drain_empty", m_valid, 0);
    chk("ovf_sticky", overflow, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ovf_clr", overflow, 0);
    step();
    rst = 1'b1;

    // Stream 0..19 through pointer wrap, ce_out-throttled, m_ready toggling.
    exp_out = 0; next_in = 0; tog = 1'b0;
    for (int cyc = 0; cyc < 200 && exp_out < 20; cyc++) begin
      DataValid = (next_in < 20) && ce_out;
      DataIn    = next_in;
      m_ready   = tog;
      #1;
      if (m_valid && m_ready) begin
        chk("stream_data", m_data, exp_out);
        exp_out++;
      end
      if (DataValid) next_in++;
      tog = ~tog;
      step();
    end
    DataValid = 1'b0; m_ready = 1'b0;
    chk("stream_count", exp_out, 20);
    chk("stream_ovf", overflow, 0);
    chk("stream_empty", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/invsqrt_out_buffer.md
INVSQRT_OUT_BUFFER -- requirements
Module: invsqrt_out_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 4..64.
REQ-002 Parameter AF_THRESH, default 3, free-entry count at or below which upstream is stalled.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 DataIn  input  32  IEEE-754 single result from the inverse-square-root pipeline.
REQ-006 DataValid  input  1  DataIn qualifier; one result per high cycle.
REQ-007 ce_out  output  1  clock enable to the upstream pipeline's ce.
REQ-008 m_data  output  32  head-of-FIFO word.
REQ-009 m_valid  output  1  m_data holds a valid word.
REQ-010 m_ready  input  1  consumer accepts m_data.
REQ-011 level  output  log2(DEPTH)+1  current occupancy.
REQ-012 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-013 The block SHALL be a first-word-fall-through circular FIFO with separate read and write pointers that wrap from DEPTH-1 to 0.
REQ-014 Write: DataValid high and (level<DEPTH or read this cycle) SHALL store DataIn at the write pointer on that edge.
REQ-015 Read: m_valid && m_ready SHALL pop the head on that edge; m_ready while m_valid low SHALL have no effect.
REQ-016 m_valid SHALL equal (level!=0); m_data SHALL present the head word whenever m_valid is high; m_data is don't-care when m_valid is low.
REQ-017 Latency: a word written at edge k SHALL appear on m_data/m_valid in the cycle after edge k when the FIFO was empty.
REQ-018 Simultaneous read and write SHALL leave level unchanged, including when full and when level==1.
REQ-019 DataValid while full with no read SHALL drop the word, leave FIFO contents and level unchanged, and set overflow.
REQ-020 overflow SHALL remain set until reset.
REQ-021 ce_out SHALL be high iff (DEPTH-level) > AF_THRESH, derived combinationally from the registered level.
REQ-022 Data order SHALL be strictly first-in first-out; no word SHALL be duplicated or reordered across pointer wrap.
REQ-023 level SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-024 rst low SHALL asynchronously clear both pointers, level, and overflow, and drive m_valid low and ce_out high.
REQ-025 Reset mid-operation SHALL discard all stored words; no stale word SHALL appear after reset release.
REQ-026 The first rising edge after rst returns high SHALL accept writes and reads normally.

Configuration
REQ-027 With macro INVSQRT_OBUF_STATS_EN defined, the block SHALL add output drop_cnt (16 bits) counting dropped words, saturating at 0xFFFF, cleared by reset.
REQ-028 Without INVSQRT_OBUF_STATS_EN, the drop_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then write 0x3F800000, 0x3F000000 on consecutive cycles with m_ready low -> level=2, m_valid=1, m_data=0x3F800000.
REQ-030 With DEPTH=8, write 8 words with m_ready low, then a 9th word 0xDEADBEEF -> level=8, overflow=1, drop_cnt=1 (macro on), and 0xDEADBEEF never appears on m_data.
REQ-031 Fill to level 5 with AF_THRESH=3 -> ce_out=0; pop one word -> ce_out=1 in the next cycle.
REQ-032 FIFO full, DataValid and m_ready high in the same cycle -> level stays 8, overflow stays 0, and the new word emerges after the 7 older words.
REQ-033 Stream 20 incrementing words with m_ready toggling every cycle -> output sequence is exactly 0..19 in order, through pointer wrap.
REQ-034 Assert rst at level 4 -> m_valid=0, level=0, overflow=0, and ce_out=1 immediately, without waiting for a clock edge.
